// File: rtl/vpu_dispatch_scoreboard.sv
// Purpose: single-entry dispatch register with a vector-register busy scoreboard (RAW/WAW) routing uops to FUs.
// Latency: one register stage, so a uop accepted in cycle N can issue in cycle N+1; one uop per cycle sustained.
// Backpressure: ready drops while a held uop cannot fire (hazard or FU not ready); valid never depends on FU ready.
package vpu_dispatch_pkg;
  localparam int FU_W   = 3;
  localparam int VREG_W = 5;

  typedef struct packed {
    logic [FU_W-1:0]   fu;
    logic [VREG_W-1:0] vd;
    logic [VREG_W-1:0] vs1;
    logic [VREG_W-1:0] vs2;
    logic              wr_vd;
    logic              rd_vs1;
    logic              rd_vs2;
  } VPU_uOP_t;
endpackage

module vpu_dispatch_scoreboard
  import vpu_dispatch_pkg::*;
#(
  parameter  int NUM_FU   = 4,
  parameter  int NUM_WB   = 2,
  parameter  int NUM_VREG = 32,
  localparam int VW       = $clog2(NUM_VREG)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dispatch_valid_i,
  input  VPU_uOP_t             dispatch_entry_i,
  output logic                 dispatch_ready_o,
  output logic [NUM_FU-1:0]    fu_valid_o,
  output VPU_uOP_t             fu_entry_o,
  input  logic [NUM_FU-1:0]    fu_ready_i,
  input  logic [NUM_WB-1:0]    wb_valid_i,
  input  logic [NUM_WB*VW-1:0] wb_vd_i,
  output logic                 idle_o,
  output logic [31:0]          stall_cnt_o
);

  typedef enum logic {ST_EMPTY, ST_HELD} state_t;

  state_t              state_q, state_d;
  VPU_uOP_t            hold_q;
  logic [NUM_VREG-1:0] busy_q, busy_d;
  logic [31:0]         stall_q;
  logic [NUM_FU-1:0]   fu_sel;
  logic                hold_valid, hazard, issue_ok, fire, accept;

  // Hazard check against registered busy bits, FU decode and the issue/accept handshake.
  always_comb begin
    fu_sel = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (hold_q.fu == FU_W'(i)) fu_sel[i] = 1'b1;
    end
    hold_valid = (state_q == ST_HELD);
    hazard     = (hold_q.rd_vs1 & busy_q[hold_q.vs1]) |
                 (hold_q.rd_vs2 & busy_q[hold_q.vs2]) |
                 (hold_q.wr_vd  & busy_q[hold_q.vd]);
    issue_ok   = hold_valid & ~hazard;
    // An out-of-range FU index decodes to no port, so such a uop is never issued.
    fu_valid_o       = issue_ok ? fu_sel : '0;
    fire             = issue_ok & (|(fu_sel & fu_ready_i));
    dispatch_ready_o = ~hold_valid | fire;
    accept           = dispatch_valid_i & dispatch_ready_o;
  end

  // Next-state: a new accept always leaves the register full; a fire alone empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_HELD;
      ST_HELD:  if (fire && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Scoreboard update: writeback clears first, then the issuing writer sets, so set wins.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid_i[k]) busy_d[wb_vd_i[k*VW +: VW]] = 1'b0;
    end
    if (fire && hold_q.wr_vd) busy_d[hold_q.vd] = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Hold register loads only on accept, keeping fu_entry_o stable until fire.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      hold_q <= '0;
    else if (accept) hold_q <= dispatch_entry_i;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Hazard stall counter; FU backpressure cycles are not hazards and are not counted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                        stall_q <= '0;
    else if (hold_valid && hazard && stall_q != '1)    stall_q <= stall_q + 32'd1;
  end

  assign fu_entry_o  = hold_q;
  assign stall_cnt_o = stall_q;
  assign idle_o      = ~hold_valid & ~(|busy_q);

  // A held uop naming a non-existent FU would sit in the register forever.
  a_legal_fu: assert property (@(posedge clk_i) disable iff (!rst_i)
                               (state_q == ST_HELD) |-> (int'(hold_q.fu) < NUM_FU));

endmodule
